// File: rtl/mips_16_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the mips_16 program loader.
// slave is the loader's view; master is the byte source / memory side.
interface mips_16_imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/mips_16_imem_loader.sv
// Framed-byte program loader: writes 16-bit words into instruction memory and holds the
// mips_16 core in reset until a checksum-valid image has been received.
module mips_16_imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_16_imem_loader_if.slave   bus,
  output logic                   core_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  // A COUNT byte of zero stands for a full memory image.
  localparam logic [CntW-1:0] FullCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StDataHi,
    StDataLo,
    StCheck,
    StRun,
    StError
  } state_e;

  state_e                state;
  logic [CntW-1:0]       remaining;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [7:0]            hi_byte;
  logic [7:0]            chk;
  logic                  accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      remaining      <= '0;
      wr_ptr         <= '0;
      hi_byte        <= '0;
      chk            <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rst       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.in_ready <= 1'b1;
      bus.imem_we  <= 1'b0;
      if (accept) begin
        case (state)
          StIdle, StRun, StError: begin
            // Headers are only recognised between frames; anything else is dropped.
            if (bus.in_data == HEADER) begin
              state    <= StCount;
              core_rst <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
            end
          end
          StCount: begin
            remaining <= (bus.in_data == 8'd0) ? FullCnt : CntW'(bus.in_data);
            wr_ptr    <= '0;
            chk       <= '0;
            state     <= StDataHi;
          end
          StDataHi: begin
            hi_byte <= bus.in_data;
            chk     <= chk ^ bus.in_data;
            state   <= StDataLo;
          end
          StDataLo: begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wr_ptr;
            bus.imem_wdata <= DATA_WIDTH'({hi_byte, bus.in_data});
            wr_ptr         <= wr_ptr + 1'b1;
            chk            <= chk ^ bus.in_data;
            remaining      <= remaining - 1'b1;
            state          <= (remaining == CntW'(1)) ? StCheck : StDataHi;
          end
          StCheck: begin
            busy <= 1'b0;
            if (bus.in_data == chk) begin
              state    <= StRun;
              core_rst <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= StError;
              err   <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/mips_16_imem_loader.md
# mips_16_imem_loader

Hardware program loader for the mips_16 core: it receives a framed byte stream, writes the decoded 16-bit instructions into the instruction memory, and holds the core in reset until a complete, checksum-valid image is in place. It sits between an external byte source (UART receiver, JTAG bridge) and the IF-stage instruction memory write port, and drives the core's reset.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction memory address width (word addressed, matches `PC_WIDTH`)
- DATA_WIDTH, 16, instruction width
- HEADER, 8'hA5, frame start byte

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte; transfer when in_valid && in_ready
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  write address
- imem_wdata  output  DATA_WIDTH  write data
- core_rst  output  1  reset to mips_16 core, active-high
- busy  output  1  frame in progress
- done  output  1  last frame loaded and verified (sticky)
- err  output  1  last frame failed checksum (sticky)

## Operation
- Frame format: HEADER, COUNT, then 2*COUNT data bytes (each word MSB first), then CHK.
- COUNT = 0 encodes 256 words (2**ADDR_WIDTH).
- CHK = XOR of all 2*COUNT data bytes. HEADER and COUNT are excluded.
- Words are written to consecutive addresses starting at 0. The address wraps modulo 2**ADDR_WIDTH and is never reached beyond COUNT.
- States and transitions:
  - IDLE: waits for HEADER → COUNT. Other bytes are consumed and dropped.
  - COUNT: latches word count, clears address and checksum → DATA_HI.
  - DATA_HI: latches the high byte → DATA_LO.
  - DATA_LO: issues the write, decrements the remaining count → DATA_HI, or → CHECK after the last word.
  - CHECK: compares the received byte with the running XOR → RUN on match, ERROR on mismatch.
  - RUN: core_rst = 0, done = 1. HEADER → COUNT; other bytes are dropped.
  - ERROR: core_rst = 1, err = 1. HEADER → COUNT; other bytes are dropped.
- In RUN, any byte equal to HEADER restarts a load: the core is re-reset and done is cleared. A byte of value A5 is only treated as a header in IDLE, RUN or ERROR, never inside a frame.
- On entering COUNT, done and err are cleared.
- core_rst = 1 in every state except RUN.
- busy = 1 in COUNT, DATA_HI, DATA_LO and CHECK.
- in_ready = 1 in every state after reset. The loader never back-pressures.
- No timeout: a stalled frame holds busy = 1 and the core in reset indefinitely.

## Timing
- Reset values: in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst = 1, busy = 0, done = 0, err = 0, state = IDLE.
- in_ready rises at the first clk edge after rst deasserts.
- A byte is accepted on the rising edge where in_valid && in_ready. The loader takes at most one byte per cycle and allows back-to-back bytes.
- Write timing: imem_we, imem_addr and imem_wdata are registered and asserted for exactly one cycle, the cycle after the low byte is accepted. Address and data hold their last value while imem_we = 0.
- Release timing: core_rst falls at the edge that accepts a matching CHK byte, so the core leaves reset 1 cycle after the last byte. done rises at the same edge.
- That edge also carries the final imem_we pulse only if CHK is accepted in the cycle immediately after the last low byte. The memory write completes at the same edge that releases core_rst, and the core's first fetch is the following cycle.
- A restart HEADER in RUN drives core_rst high at the accepting edge.
- rst asserted mid-frame:
  - immediately returns all outputs to their reset values;
  - partially written memory contents are not cleared;
  - the core stays in reset until a new valid frame completes.
- in_valid low mid-frame stalls the state machine with no state change.

## Test plan
- Basic load: rst pulse, then A5, 02, 12, 34, AB, CD, CHK = 12^34^AB^CD = 40 → writes (0, 1234) and (1, ABCD), one imem_we pulse each; core_rst falls 1 cycle after CHK; done = 1, err = 0.
- Bad checksum: same frame with CHK = 41 → both words are still written; core_rst stays 1; err = 1, done = 0. A following valid frame recovers to done = 1.
- Full image: COUNT = 00, 512 data bytes with word i = i → 256 writes at addresses 0..255, no extra write; done = 1.
- Garbage and stalls: bytes 00, FF before A5 are dropped; within the frame, in_valid drops for 3 cycles between bytes → identical writes and result to the basic load.
- Reload while running: after a successful load, send A5, 01, 00, 00, 00 → core_rst goes high at the A5 edge and done clears; after CHK, address 0 holds 0000 and core_rst returns low.
- Reset mid-frame: assert rst after the 3rd data byte → outputs return to reset values immediately (core_rst = 1); a subsequent full frame loads correctly.
